uart_tx_ctrl: RTL and testbench

Frame controller for the UART transmitter. Sits directly upstream of the registered 8:1 output multiplexer: it accepts a parallel byte with a valid strobe, then steps the mux select through start, data (LSB first), optional parity and stop bits. It also drives the 8-bit mux data vector whose lanes carry the fixed and per-bit line levels. The mux registers its output, so the serial line lags this block's select by one clock.

---
 rtl/uart_tx_pkg.sv | 43 ++++
 rtl/uart_parity_calc.sv | 10 +
 rtl/uart_tx_ctrl.sv | 148 ++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit frame controller:
// FSM states, output-mux select codes and the mux lane map.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic [2:0] SEL_START = 3'd0;
  localparam logic [2:0] SEL_STOP  = 3'd1;
  localparam logic [2:0] SEL_DATA  = 3'd2;
  localparam logic [2:0] SEL_PAR   = 3'd3;
  localparam logic [2:0] SEL_IDLE  = 3'd4;

  localparam int LANE_START = 0;
  localparam int LANE_STOP  = 1;
  localparam int LANE_DATA  = 2;
  localparam int LANE_PAR   = 3;

  // Lanes 4-7 park the line high whenever SEL_IDLE is selected.
  localparam logic [7:0] IDLE_LANES = 8'hF0;

  // Assemble the mux lane vector from the two per-bit lane levels.
  function automatic logic [7:0] lane_vector(input logic data_bit, input logic par_bit);
    logic [7:0] v;
    v             = IDLE_LANES;
    v[LANE_START] = 1'b0;
    v[LANE_STOP]  = 1'b1;
    v[LANE_DATA]  = data_bit;
    v[LANE_PAR]   = par_bit;
    return v;
  endfunction

  // Bit-timer width: clog2 of the prescale, never narrower than one bit.
  function automatic int timer_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/uart_parity_calc.sv
// Parity of a byte: even parity when par_typ=0, odd parity when par_typ=1.
module uart_parity_calc (
  input  logic [7:0] data,
  input  logic       par_typ,
  output logic       parity
);

  assign parity = (^data) ^ par_typ;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: walks the output-mux select through
// start, LSB-first data, optional parity and stop bits, PRESCALE clocks each.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_valid,
  input  logic [7:0] p_data,
  input  logic       par_en,
  input  logic       par_typ,
  output logic [2:0] mux_sel,
  output logic [7:0] mux_data,
  output logic       busy
);

  localparam int             CW       = timer_width(PRESCALE);
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

  // Handshake: data_valid is a one-clock-sampled strobe with no ready; a byte
  // is taken only on an edge where the FSM is in IDLE or on the last STOP clock,
  // and busy=1 signals that any other data_valid will be ignored.

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    data_q;
  logic          par_en_q;
  logic          par_typ_q;
  logic          data_lane;
  logic          par_lane;
  logic          par_bit;
  logic          bit_end;

  assign bit_end = (cnt == CNT_LAST);

  uart_parity_calc u_parity (
    .data    (data_q),
    .par_typ (par_typ_q),
    .parity  (par_bit)
  );

  // The lane vector is a fixed wiring of two registered lane levels.
  assign mux_data = lane_vector(data_lane, par_lane);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      idx       <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      data_lane <= 1'b0;
      par_lane  <= 1'b0;
      mux_sel   <= SEL_IDLE;
      busy      <= 1'b0;
    end else begin
      // The latched byte is stable long before PARITY, so track it every clock.
      par_lane <= par_bit;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          idx <= '0;
          if (data_valid) begin
            data_q    <= p_data;
            par_en_q  <= par_en;
            par_typ_q <= par_typ;
            state     <= ST_START;
            mux_sel   <= SEL_START;
            busy      <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_end) begin
            cnt       <= '0;
            idx       <= '0;
            data_lane <= data_q[0];
            state     <= ST_DATA;
            mux_sel   <= SEL_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (idx == 3'd7) begin
              idx <= '0;
              if (par_en_q) begin
                state   <= ST_PARITY;
                mux_sel <= SEL_PAR;
              end else begin
                state   <= ST_STOP;
                mux_sel <= SEL_STOP;
              end
            end else begin
              idx       <= idx + 3'd1;
              data_lane <= data_q[idx + 3'd1];
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            cnt     <= '0;
            state   <= ST_STOP;
            mux_sel <= SEL_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            cnt <= '0;
            idx <= '0;
            // A byte offered on the last stop clock starts the next frame with no idle gap.
            if (data_valid) begin
              data_q    <= p_data;
              par_en_q  <= par_en;
              par_typ_q <= par_typ;
              state     <= ST_START;
              mux_sel   <= SEL_START;
              busy      <= 1'b1;
            end else begin
              state   <= ST_IDLE;
              mux_sel <= SEL_IDLE;
              busy    <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state   <= ST_IDLE;
          cnt     <= '0;
          idx     <= '0;
          mux_sel <= SEL_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl at PRESCALE=1 and PRESCALE=4 against a frame-list
// model: each accepted byte expands into a list of {select, line level} per clock.
module tb_uart_tx_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       dv1, pe1, pt1, busy1;
  logic [7:0] pd1, md1;
  logic [2:0] sel1;
  logic       dv4, pe4, pt4, busy4;
  logic [7:0] pd4, md4;
  logic [2:0] sel4;

  uart_tx_ctrl #(.PRESCALE(1)) u_dut1 (
    .clk(clk), .rst(rst), .data_valid(dv1), .p_data(pd1), .par_en(pe1), .par_typ(pt1),
    .mux_sel(sel1), .mux_data(md1), .busy(busy1)
  );

  uart_tx_ctrl #(.PRESCALE(4)) u_dut4 (
    .clk(clk), .rst(rst), .data_valid(dv4), .p_data(pd4), .par_en(pe4), .par_typ(pt4),
    .mux_sel(sel4), .mux_data(md4), .busy(busy4)
  );

  int checks = 0;
  int errors = 0;

  logic [3:0] exp1_q[$];
  logic [3:0] exp4_q[$];
  logic       obs1_q[$];
  logic       obs4_q[$];
  logic       line1, line4;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame bit b as {select code, line level}: start, 8 data LSB first, parity, stop.
  function automatic logic [3:0] frame_bit(input logic [7:0] d, input logic pe,
                                           input logic pt, input int b);
    if (b == 0) return {3'd0, 1'b0};
    if (b <= 8) return {3'd2, d[b-1]};
    if (pe && b == 9) return {3'd3, (^d) ^ pt};
    return {3'd1, 1'b1};
  endfunction

  // Registered downstream mux: the serial line one clock behind the select.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      line1 <= 1'b1;
      line4 <= 1'b1;
    end else begin
      line1 <= md1[sel1];
      line4 <= md4[sel4];
    end
  end

  always @(posedge clk) begin
    logic [3:0] e;
    logic       lvl_before;
    logic       accept;
    if (rst) begin
      exp1_q.delete();
    end else begin
      lvl_before = (exp1_q.size() != 0) ? exp1_q[0][0] : 1'b1;
      accept = dv1 && (exp1_q.size() <= 1);
      if (exp1_q.size() != 0) void'(exp1_q.pop_front());
      if (accept)
        for (int b = 0; b < (pe1 ? 11 : 10); b++) exp1_q.push_back(frame_bit(pd1, pe1, pt1, b));
      #1;
      e = (exp1_q.size() != 0) ? exp1_q[0] : {3'd4, 1'b1};
      check("sel1", sel1, e[3:1]);
      check("busy1", busy1, exp1_q.size() != 0);
      check("fixed_lanes1", md1 & 8'hF3, 8'hF2);
      check("level1", md1[sel1], e[0]);
      check("line1", line1, lvl_before);
      if (busy1) obs1_q.push_back(md1[sel1]);
    end
  end

  always @(posedge clk) begin
    logic [3:0] e;
    logic       lvl_before;
    logic       accept;
    if (rst) begin
      exp4_q.delete();
    end else begin
      lvl_before = (exp4_q.size() != 0) ? exp4_q[0][0] : 1'b1;
      accept = dv4 && (exp4_q.size() <= 1);
      if (exp4_q.size() != 0) void'(exp4_q.pop_front());
      if (accept)
        for (int b = 0; b < (pe4 ? 11 : 10); b++)
          for (int r = 0; r < 4; r++) exp4_q.push_back(frame_bit(pd4, pe4, pt4, b));
      #1;
      e = (exp4_q.size() != 0) ? exp4_q[0] : {3'd4, 1'b1};
      check("sel4", sel4, e[3:1]);
      check("busy4", busy4, exp4_q.size() != 0);
      check("fixed_lanes4", md4 & 8'hF3, 8'hF2);
      check("level4", md4[sel4], e[0]);
      check("line4", line4, lvl_before);
      if (busy4) obs4_q.push_back(md4[sel4]);
    end
  end

  task automatic pulse1(input logic [7:0] d, input logic pe, input logic pt);
    @(negedge clk);
    dv1 = 1'b1; pd1 = d; pe1 = pe; pt1 = pt;
    @(negedge clk);
    dv1 = 1'b0;
  endtask

  task automatic pulse4(input logic [7:0] d, input logic pe, input logic pt);
    @(negedge clk);
    dv4 = 1'b1; pd4 = d; pe4 = pe; pt4 = pt;
    @(negedge clk);
    dv4 = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp1_q.size() != 0 || exp4_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_timeout", exp1_q.size() + exp4_q.size(), 0);
  endtask

  function automatic int pack1(input int first, input int n);
    int v = 0;
    for (int i = 0; i < n; i++)
      if (first + i < obs1_q.size() && obs1_q[first + i]) v |= (1 << i);
    return v;
  endfunction

  initial begin
    int n;
    rst = 1'b1;
    dv1 = 1'b0; pd1 = 8'h00; pe1 = 1'b0; pt1 = 1'b0;
    dv4 = 1'b0; pd4 = 8'h00; pe4 = 1'b0; pt4 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sel1", sel1, 4);
    check("rst_data1", md1, 8'hF2);
    check("rst_busy1", busy1, 0);
    check("rst_sel4", sel4, 4);
    check("rst_data4", md4, 8'hF2);
    check("rst_busy4", busy4, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // A5, no parity: line 0,1,0,1,0,0,1,0,1,1 and busy for 10 clocks.
    obs1_q.delete();
    pulse1(8'hA5, 1'b0, 1'b0);
    wait_idle(100);
    check("a5_len", obs1_q.size(), 10);
    check("a5_line", pack1(0, 10), 10'b1101001010);

    // 07 with even then odd parity: parity lane 1 then 0, 11-clock frame.
    obs1_q.delete();
    pulse1(8'h07, 1'b1, 1'b0);
    wait_idle(100);
    check("par_even_len", obs1_q.size(), 11);
    check("par_even_bit", pack1(9, 1), 1);
    obs1_q.delete();
    pulse1(8'h07, 1'b1, 1'b1);
    wait_idle(100);
    check("par_odd_len", obs1_q.size(), 11);
    check("par_odd_bit", pack1(9, 1), 0);

    // Back-to-back: 3C offered on the last STOP clock of an A5 frame.
    obs1_q.delete();
    pulse1(8'hA5, 1'b0, 1'b0);
    n = 0;
    while (exp1_q.size() != 1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("b2b_reach_stop", exp1_q.size(), 1);
    dv1 = 1'b1; pd1 = 8'h3C;
    @(negedge clk);
    dv1 = 1'b0;
    check("b2b_no_gap", busy1, 1);
    wait_idle(100);
    check("b2b_len", obs1_q.size(), 20);
    check("b2b_first", pack1(0, 10), 10'b1101001010);
    check("b2b_second", pack1(10, 10), 10'b1001111000);

    // Inputs changed mid-DATA are ignored.
    obs1_q.delete();
    pulse1(8'hA5, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    dv1 = 1'b1; pd1 = 8'hFF; pe1 = 1'b1;
    @(negedge clk);
    dv1 = 1'b0;
    wait_idle(100);
    repeat (3) @(negedge clk);
    check("ign_len", obs1_q.size(), 10);
    check("ign_line", pack1(0, 10), 10'b1101001010);
    check("ign_no_extra", busy1, 0);

    // Reset mid-DATA takes effect before the next clock edge.
    pulse1(8'hA5, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_sel1", sel1, 4);
    check("midrst_data1", md1, 8'hF2);
    check("midrst_busy1", busy1, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_stays_idle", busy1, 0);

    // PRESCALE=4: 01 gives a 40-clock frame, 44 with parity.
    obs4_q.delete();
    pulse4(8'h01, 1'b0, 1'b0);
    wait_idle(200);
    check("p4_len", obs4_q.size(), 40);
    check("p4_start_end", (obs4_q.size() == 40) ? obs4_q[3] : 1, 0);
    check("p4_bit0", (obs4_q.size() == 40) ? {obs4_q[4], obs4_q[7]} : 0, 2'b11);
    check("p4_bit1", (obs4_q.size() == 40) ? obs4_q[8] : 1, 0);
    obs4_q.delete();
    pulse4(8'h01, 1'b1, 1'b0);
    wait_idle(200);
    check("p4_par_len", obs4_q.size(), 44);
    check("p4_par_bit", (obs4_q.size() == 44) ? {obs4_q[36], obs4_q[39]} : 0, 2'b11);

    // Random traffic on both instances; the model decides which strobes are taken.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      dv1 = ($urandom_range(0, 3) == 0);
      pd1 = 8'($urandom);
      pe1 = 1'($urandom_range(0, 1));
      pt1 = 1'($urandom_range(0, 1));
      dv4 = ($urandom_range(0, 7) == 0);
      pd4 = 8'($urandom);
      pe4 = 1'($urandom_range(0, 1));
      pt4 = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    dv1 = 1'b0;
    dv4 = 1'b0;
    wait_idle(200);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
